// File: rtl/smol_mult_spi_pkg.sv
// Shared definitions for the SPI 4x4 multiplier slave: default sizes,
// FSM state encoding and the SCLK edge-pulse bundle.
package smol_mult_spi_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int SYNC_DEF  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RX   = 2'd1,
      CALC = 2'd2,
      TX   = 2'd3
   } state_e;

   typedef struct packed {
      logic rise;
      logic fall;
   } sclk_edge_t;

endpackage

// File: rtl/smol_mult_spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous serial clock plus one-CLK
// rise/fall pulses derived from the synchronised history.
module spi_sync_edge
   import smol_mult_spi_pkg::*;
#(
   parameter int SYNC = SYNC_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       d_i,
   output sclk_edge_t edge_o
);

   logic [SYNC-1:0] sync_q;
   logic            prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], d_i};
         prev_q <= sync_q[SYNC-1];
      end
   end

   always_comb begin
      edge_o.rise = sync_q[SYNC-1] & ~prev_q;
      edge_o.fall = ~sync_q[SYNC-1] & prev_q;
   end

endmodule

// File: rtl/smol_mult_spi.sv
// SPI slave that receives A then B (MSB first), multiplies them and returns
// the product MSB first on MISO, recirculating while CS stays high.
module smol_mult_spi
   import smol_mult_spi_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SYNC  = SYNC_DEF
) (
   input  logic   CLK,
   input  logic   RST,
   input  logic   SCLK,
   input  logic   CS,
   input  logic   MOSI,
   output logic   MISO,
   output state_e dbg_state_o
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(PW);

   logic [SYNC-1:0] cs_sync_q;
   logic [SYNC-1:0] mosi_sync_q;
   logic            cs_s;
   logic            mosi_s;
   sclk_edge_t      sclk_edge;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   rx_q, rx_d;
   logic [PW-1:0]   tx_q, tx_d;
   logic            skip_q, skip_d;
   logic [PW-1:0]   op_a, op_b, product;

   spi_sync_edge #(.SYNC(SYNC)) u_sclk_sync (
      .clk_i  (CLK),
      .rst_i  (RST),
      .d_i    (SCLK),
      .edge_o (sclk_edge)
   );

   assign cs_s   = cs_sync_q[SYNC-1];
   assign mosi_s = mosi_sync_q[SYNC-1];

   assign op_a    = {{WIDTH{1'b0}}, rx_q[PW-1:WIDTH]};
   assign op_b    = {{WIDTH{1'b0}}, rx_q[WIDTH-1:0]};
   assign product = op_a * op_b;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         skip_q      <= 1'b0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC-2:0], CS};
         mosi_sync_q <= {mosi_sync_q[SYNC-2:0], MOSI};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         skip_q      <= skip_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!cs_s) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = RX;
            RX:      if (sclk_edge.rise && cnt_q == CW'(PW - 1)) state_d = CALC;
            CALC:    state_d = TX;
            TX:      state_d = TX;
            default: state_d = IDLE;
         endcase
      end
   end

   // The falling edge closing the last input bit arrives after CALC; it is
   // swallowed so P[MSB] stays on MISO for the first output sample.
   always_comb begin
      cnt_d  = cnt_q;
      rx_d   = rx_q;
      tx_d   = tx_q;
      skip_d = skip_q;
      if (!cs_s || state_q == IDLE) begin
         cnt_d  = '0;
         rx_d   = '0;
         tx_d   = '0;
         skip_d = 1'b0;
      end else begin
         case (state_q)
            RX: begin
               if (sclk_edge.rise) begin
                  rx_d  = {rx_q[PW-2:0], mosi_s};
                  cnt_d = cnt_q + 1'b1;
               end
            end
            CALC: begin
               tx_d   = product;
               skip_d = 1'b1;
            end
            TX: begin
               if (sclk_edge.fall) begin
                  if (skip_q) skip_d = 1'b0;
                  else        tx_d   = {tx_q[PW-2:0], tx_q[PW-1]};
               end
            end
            default: ;
         endcase
      end
   end

   assign MISO        = tx_q[PW-1];
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_smol_mult_spi.sv
// Directed + randomised bench for smol_mult_spi acting as an SPI mode-0 master.
module tb_smol_mult_spi;
   import smol_mult_spi_pkg::*;

   localparam int HALF = 8;

   logic   CLK = 1'b0;
   logic   RST, SCLK, CS, MOSI, MISO;
   state_e dbg_state;
   int     total = 0;
   int     bad = 0;
   logic   exp_q[$];

   smol_mult_spi dut (
      .CLK         (CLK),
      .RST         (RST),
      .SCLK        (SCLK),
      .CS          (CS),
      .MOSI        (MOSI),
      .MISO        (MISO),
      .dbg_state_o (dbg_state)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One SCLK period, idle low: present MOSI, sample MISO just before the rise.
   task automatic sclk_cycle(input logic mosi_v, output logic miso_v);
      MOSI = mosi_v;
      repeat (HALF) @(negedge CLK);
      miso_v = MISO;
      SCLK = 1'b1;
      repeat (HALF) @(negedge CLK);
      SCLK = 1'b0;
   endtask

   task automatic end_frame(input string tag);
      CS = 1'b0;
      repeat (5) @(negedge CLK);
      check({tag, "_idle_miso"}, 8'(MISO), 8'd0);
      check({tag, "_idle_state"}, 8'(dbg_state), 8'(IDLE));
   endtask

   task automatic run_frame(input logic [3:0] a, input logic [3:0] b, input int nreads,
                            input string tag);
      logic [7:0] word;
      logic [7:0] p;
      logic       m;
      CS = 1'b1;
      repeat (4) @(negedge CLK);
      word = {a, b};
      for (int i = 7; i >= 0; i--) begin
         sclk_cycle(word[i], m);
         check($sformatf("%s_rx_miso%0d", tag, i), 8'(m), 8'd0);
      end
      check({tag, "_tx_state"}, 8'(dbg_state), 8'(TX));
      p = 8'(a) * 8'(b);
      for (int n = 0; n < nreads; n++) exp_q.push_back(p[7 - (n % 8)]);
      for (int n = 0; n < nreads; n++) begin
         sclk_cycle(1'($urandom_range(0, 1)), m);
         check($sformatf("%s_bit%0d", tag, n), 8'(m), 8'(exp_q.pop_front()));
      end
   endtask

   initial begin
      logic m;
      RST = 1'b1; CS = 1'b0; SCLK = 1'b0; MOSI = 1'b0;
      repeat (5) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check("reset_miso", 8'(MISO), 8'd0);
      check("reset_state", 8'(dbg_state), 8'(IDLE));

      // SCLK activity with CS low must be ignored
      for (int i = 0; i < 8; i++) begin
         sclk_cycle(1'($urandom_range(0, 1)), m);
         check("cs_low_miso", 8'(m), 8'd0);
      end
      check("cs_low_state", 8'(dbg_state), 8'(IDLE));

      run_frame(4'b0001, 4'b0110, 8, "p6");
      end_frame("p6");
      run_frame(4'b1111, 4'b1111, 16, "p225");
      end_frame("p225");
      run_frame(4'b0000, 4'b1011, 8, "p0");
      end_frame("p0");
      run_frame(4'b1010, 4'b0001, 8, "p10");
      end_frame("p10");

      for (int r = 0; r < 6; r++) begin
         run_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   (r % 2 == 0) ? 8 : 16, $sformatf("rnd%0d", r));
         end_frame($sformatf("rnd%0d", r));
      end

      // Abort after five input bits; the next frame must show no stale bits
      CS = 1'b1;
      repeat (4) @(negedge CLK);
      for (int i = 0; i < 5; i++) sclk_cycle(1'b1, m);
      end_frame("abort");
      run_frame(4'b0011, 4'b0011, 8, "p9");

      // Reset in the middle of TX
      for (int i = 0; i < 3; i++) sclk_cycle(1'b0, m);
      RST = 1'b1;
      @(negedge CLK);
      check("rst_tx_miso", 8'(MISO), 8'd0);
      check("rst_tx_state", 8'(dbg_state), 8'(IDLE));
      RST = 1'b0;
      end_frame("post_rst");
      run_frame(4'b0010, 4'b0011, 8, "fresh");
      end_frame("fresh");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
